// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stall merge, multi-cycle EX holds,
// exception flush/redirect and a saturating stall-cycle counter.
module pipe_ctrl #(
    parameter int CNT_W    = 32,
    parameter int MC_LEN_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stallreq_if,
    input  logic                stallreq_id,
    input  logic                stallreq_ex,
    input  logic                stallreq_mem,
    input  logic                mc_start,
    input  logic [MC_LEN_W-1:0] mc_len,
    input  logic                excp_req,
    input  logic [31:0]         excp_vec,
    input  logic                cnt_clr,
    output logic [5:0]          stall,
    output logic                flush,
    output logic [31:0]         new_pc,
    output logic                mc_done,
    output logic                mc_abort,
    output logic [CNT_W-1:0]    stall_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam logic [5:0] SV_IF  = 6'b000011;
    localparam logic [5:0] SV_ID  = 6'b000111;
    localparam logic [5:0] SV_EX  = 6'b001111;
    localparam logic [5:0] SV_MEM = 6'b011111;

    localparam logic [MC_LEN_W-1:0] LEN_ONE = MC_LEN_W'(1);
    localparam logic [MC_LEN_W-1:0] LEN_TWO = MC_LEN_W'(2);

    state_e              state_q, state_d;
    logic [MC_LEN_W-1:0] cnt_q, cnt_d;
    logic                flush_q, flush_d;
    logic                abort_q, abort_d;
    logic [31:0]         pc_q, pc_d;
    logic [CNT_W-1:0]    scnt_q, scnt_d;
    logic [5:0]          req_vec;
    logic                mc_hold;

    // Merge level stall requests with the EX hold of a multi-cycle op.
    always_comb begin
        req_vec = 6'b0;
        if (stallreq_if)  req_vec = req_vec | SV_IF;
        if (stallreq_id)  req_vec = req_vec | SV_ID;
        if (stallreq_ex)  req_vec = req_vec | SV_EX;
        if (stallreq_mem) req_vec = req_vec | SV_MEM;
        mc_hold = (state_q == HOLD) ||
                  (state_q == RUN && mc_start && mc_len != '0);
        if (reset || state_q == FLUSH) begin
            stall = 6'b0;
        end else begin
            stall = req_vec | (mc_hold ? SV_EX : 6'b0);
        end
        // An exception in the final held cycle kills the op: no done.
        mc_done = !reset && !excp_req &&
                  ((state_q == RUN && mc_start && mc_len == LEN_ONE) ||
                   (state_q == HOLD && cnt_q == '0));
    end

    // Next-state logic for the hold/flush sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flush_d = 1'b0;
        abort_d = 1'b0;
        pc_d    = pc_q;
        unique case (state_q)
            RUN: begin
                if (excp_req) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                    flush_d = 1'b1;
                    pc_d    = excp_vec;
                end else if (mc_start && mc_len >= LEN_TWO) begin
                    state_d = HOLD;
                    cnt_d   = mc_len - LEN_TWO;
                end
            end
            HOLD: begin
                if (excp_req) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                    flush_d = 1'b1;
                    abort_d = 1'b1;
                    pc_d    = excp_vec;
                end else if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - LEN_ONE;
                end
            end
            FLUSH: begin
                state_d = RUN;
                cnt_d   = '0;
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Sequencer state and its registered flush/redirect/abort outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            flush_q <= 1'b0;
            abort_q <= 1'b0;
            pc_q    <= 32'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            abort_q <= abort_d;
            pc_q    <= pc_d;
        end
    end

    // Stall-cycle counter: saturates at all-ones, clear wins.
    always_comb begin
        scnt_d = scnt_q;
        if (cnt_clr) begin
            scnt_d = '0;
        end else if (stall[0] && scnt_q != '1) begin
            scnt_d = scnt_q + CNT_W'(1);
        end
    end

    // Register the performance counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scnt_q <= '0;
        end else begin
            scnt_q <= scnt_d;
        end
    end

    assign flush     = flush_q;
    assign new_pc    = pc_q;
    assign mc_abort  = abort_q;
    assign stall_cnt = scnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios then random traffic,
// checked against a cycle-count model of the sequencing rules.
module tb_pipe_ctrl;

    localparam int CW   = 8;
    localparam int MAXC = 255;

    logic          clk = 1'b0;
    logic          reset;
    logic          sif, sid, sex, smem;
    logic          mc_start;
    logic [3:0]    mc_len;
    logic          excp_req;
    logic [31:0]   excp_vec;
    logic          cnt_clr;
    logic [5:0]    stall;
    logic          flush;
    logic [31:0]   new_pc;
    logic          mc_done;
    logic          mc_abort;
    logic [CW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // model: held cycles still owed, pending flush, captured pc, counter
    int          m_rem;
    bit          m_flush;
    bit          m_abort;
    logic [31:0] m_pc;
    int          m_cnt;
    logic [5:0]  e_stall;
    bit          e_done;
    bit          held;
    int          rem_now;

    pipe_ctrl #(.CNT_W(CW), .MC_LEN_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .stallreq_if  (sif),
        .stallreq_id  (sid),
        .stallreq_ex  (sex),
        .stallreq_mem (smem),
        .mc_start     (mc_start),
        .mc_len       (mc_len),
        .excp_req     (excp_req),
        .excp_vec     (excp_vec),
        .cnt_clr      (cnt_clr),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .mc_done      (mc_done),
        .mc_abort     (mc_abort),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_rem   = 0;
        m_flush = 0;
        m_abort = 0;
        m_pc    = 32'h0;
        m_cnt   = 0;
    endtask

    task automatic drive(input logic [3:0] req, input logic ms,
                         input logic [3:0] ml, input logic ex,
                         input logic [31:0] ev, input logic clr);
        {smem, sex, sid, sif} = req;
        mc_start = ms;
        mc_len   = ml;
        excp_req = ex;
        excp_vec = ev;
        cnt_clr  = clr;
    endtask

    task automatic checkm();
        int reqv;
        @(negedge clk);
        reqv = 0;
        if (sif)  reqv = reqv | 3;
        if (sid)  reqv = reqv | 7;
        if (sex)  reqv = reqv | 15;
        if (smem) reqv = reqv | 31;
        held    = 0;
        rem_now = 0;
        e_stall = 6'b0;
        e_done  = 0;
        if (!m_flush) begin
            rem_now = m_rem;
            if (m_rem > 0) begin
                held = 1;
            end else if (mc_start && mc_len != 0) begin
                held    = 1;
                rem_now = int'(mc_len);
            end
            e_stall = reqv[5:0] | (held ? 6'b001111 : 6'b0);
            e_done  = held && rem_now == 1 && !excp_req;
        end
        chk("stall", {26'b0, stall}, {26'b0, e_stall});
        chk("flush", {31'b0, flush}, {31'b0, m_flush});
        chk("mc_done", {31'b0, mc_done}, {31'b0, e_done});
        chk("mc_abort", {31'b0, mc_abort}, {31'b0, m_abort});
        chk("stall_cnt", {24'b0, stall_cnt}, m_cnt);
        if (m_flush) chk("new_pc", new_pc, m_pc);
    endtask

    task automatic adv();
        if (cnt_clr) m_cnt = 0;
        else if (e_stall[0] && m_cnt < MAXC) m_cnt++;
        if (m_flush) begin
            m_flush = 0;
            m_abort = 0;
            m_rem   = 0;
        end else if (excp_req) begin
            m_flush = 1;
            m_pc    = excp_vec;
            m_abort = (m_rem > 0);
            m_rem   = 0;
        end else begin
            m_abort = 0;
            m_rem   = held ? rem_now - 1 : 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic [3:0] req, input logic ms,
                       input logic [3:0] ml, input logic ex,
                       input logic [31:0] ev, input logic clr);
        drive(req, ms, ml, ex, ev, clr);
        checkm();
        adv();
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_stall"}, {26'b0, stall}, 32'h0);
        chk({tag, "_flush"}, {31'b0, flush}, 32'h0);
        chk({tag, "_newpc"}, new_pc, 32'h0);
        chk({tag, "_done"}, {31'b0, mc_done}, 32'h0);
        chk({tag, "_abort"}, {31'b0, mc_abort}, 32'h0);
        chk({tag, "_cnt"}, {24'b0, stall_cnt}, 32'h0);
    endtask

    initial begin
        logic [3:0]  rq;
        logic        rms, rex, rclr;
        logic [3:0]  rml;
        logic [31:0] rev;

        reset = 1'b1;
        drive(4'b0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        all_zero("reset");
        reset = 1'b0;

        // level ID stall for three cycles
        for (int i = 0; i < 3; i++) begin
            drive(4'b0010, 1'b0, 4'd0, 1'b0, 32'h0, 1'b0);
            checkm();
            chk("t1_stall", {26'b0, stall}, 32'h07);
            adv();
        end
        drive(4'b0000, 1'b0, 4'd0, 1'b0, 32'h0, 1'b0);
        checkm();
        chk("t1_idle", {26'b0, stall}, 32'h0);
        chk("t1_cnt", {24'b0, stall_cnt}, 32'd3);
        adv();

        // ID plus MEM together
        drive(4'b1010, 1'b0, 4'd0, 1'b0, 32'h0, 1'b0);
        checkm();
        chk("t2_stall", {26'b0, stall}, 32'h1f);
        adv();

        // four-cycle multi-cycle op
        drive(4'b0, 1'b1, 4'd4, 1'b0, 32'h0, 1'b0);
        checkm();
        chk("t3_s0", {26'b0, stall}, 32'h0f);
        chk("t3_d0", {31'b0, mc_done}, 32'h0);
        adv();
        for (int i = 1; i < 3; i++) begin
            drive(4'b0, 1'b1, 4'd9, 1'b0, 32'h0, 1'b0);
            checkm();
            chk("t3_s", {26'b0, stall}, 32'h0f);
            chk("t3_d", {31'b0, mc_done}, 32'h0);
            adv();
        end
        drive(4'b0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b0);
        checkm();
        chk("t3_s3", {26'b0, stall}, 32'h0f);
        chk("t3_d3", {31'b0, mc_done}, 32'h1);
        adv();
        checkm();
        chk("t3_s4", {26'b0, stall}, 32'h0);
        chk("t3_d4", {31'b0, mc_done}, 32'h0);
        adv();

        // length one, then length zero
        drive(4'b0, 1'b1, 4'd1, 1'b0, 32'h0, 1'b0);
        checkm();
        chk("t4_s1", {26'b0, stall}, 32'h0f);
        chk("t4_d1", {31'b0, mc_done}, 32'h1);
        adv();
        drive(4'b0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b0);
        checkm();
        chk("t4_after", {26'b0, stall}, 32'h0);
        adv();
        drive(4'b0, 1'b1, 4'd0, 1'b0, 32'h0, 1'b0);
        checkm();
        chk("t4_s0", {26'b0, stall}, 32'h0);
        chk("t4_d0", {31'b0, mc_done}, 32'h0);
        adv();

        // exception kills a held op
        cyc(4'b0, 1'b1, 4'd8, 1'b0, 32'h0, 1'b0);
        cyc(4'b0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b0);
        drive(4'b0, 1'b0, 4'd0, 1'b1, 32'h20, 1'b0);
        checkm();
        chk("t5_hold", {26'b0, stall}, 32'h0f);
        adv();
        drive(4'b1000, 1'b0, 4'd0, 1'b1, 32'h44, 1'b0);
        checkm();
        chk("t5_flush", {31'b0, flush}, 32'h1);
        chk("t5_pc", new_pc, 32'h20);
        chk("t5_abort", {31'b0, mc_abort}, 32'h1);
        chk("t5_stall", {26'b0, stall}, 32'h0);
        adv();
        drive(4'b0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b0);
        checkm();
        chk("t5_run", {31'b0, flush}, 32'h0);
        chk("t5_noab", {31'b0, mc_abort}, 32'h0);
        adv();

        // async reset mid-hold
        cyc(4'b0, 1'b1, 4'd8, 1'b0, 32'h0, 1'b0);
        drive(4'b0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        all_zero("t6_rst");
        model_reset();
        @(posedge clk);
        #1;
        all_zero("t6_hold");
        reset = 1'b0;
        cyc(4'b0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b0);

        // counter saturation and clear
        for (int i = 0; i < 270; i++) begin
            cyc(4'b0001, 1'b0, 4'd0, 1'b0, 32'h0, 1'b0);
        end
        drive(4'b0001, 1'b0, 4'd0, 1'b0, 32'h0, 1'b1);
        checkm();
        chk("t6_sat", {24'b0, stall_cnt}, MAXC);
        adv();
        drive(4'b0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b0);
        checkm();
        chk("t6_clr", {24'b0, stall_cnt}, 32'h0);
        adv();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            rq   = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            rex  = ($urandom_range(0, 9) == 0);
            rms  = !rex && ($urandom_range(0, 3) == 0);
            rml  = 4'($urandom_range(0, 15));
            rev  = $urandom;
            rclr = ($urandom_range(0, 29) == 0);
            cyc(rq, rms, rml, rex, rev, rclr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
